cpu_boot_ctrl: RTL and testbench
================================

# cpu_boot_ctrl

Run controller for the 16-bit single-cycle CPU. It sequences the CPU through program load, PC reset and run. It streams host words into instruction memory over a valid/ready handshake, holds the PC in reset, and enables execution. It then stops the CPU on a halt indication or on watchdog expiry. It sits between the host/test interface and the CPU's `instruction_in`/`load_instruction`/`pc_reset` pins.

## Interface
- `ADDR_W`, 8: instruction memory address width; depth = 2**ADDR_W words.
- `RST_CYC`, 2: cycles `pc_reset` is held in RESET_CPU (≥1).
- `CNT_W`, 16: width of cycle counter and watchdog limit.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `load_start` in 1: pulse; begin a program load.
- `load_len` in ADDR_W+1: number of words to load, sampled with `load_start`.
- `run_start` in 1: pulse; reset the PC and run the loaded program.
- `abort` in 1: return to IDLE from any state.
- `host_data` in 16: program word.
- `host_valid` in 1: `host_data` is valid.
- `host_ready` out 1: the controller accepts a word.
- `cpu_halt` in 1: the CPU is executing a halt instruction.
- `wdog_limit` in CNT_W: maximum RUN cycles; 0 disables the watchdog.
- `instruction_in` out 16: write data to instruction memory.
- `load_instruction` out 1: instruction memory write strobe.
- `load_addr` out ADDR_W: instruction memory write address.
- `pc_reset` out 1: active-high PC reset to the CPU.
- `cpu_en` out 1: CPU clock enable.
- `state` out 3: current FSM state encoding.
- `done` out 1, `timeout` out 1: status flags.
- `cycle_count` out CNT_W: RUN cycles executed.

## Operation
- States: IDLE=0, LOAD=1, RESET_CPU=2, RUN=3, DONE=4, TIMEOUT=5.
- Reset values:
  - state IDLE.
  - `pc_reset`=1.
  - `cpu_en`, `host_ready`, `load_instruction`, `done`, `timeout` = 0.
  - `load_addr`, `instruction_in`, `cycle_count` = 0.
- IDLE/DONE/TIMEOUT handling of start pulses:
  - `load_start` with `load_len`≠0 → LOAD. Captures `min(load_len, 2**ADDR_W)` as the remaining count and clears the address to 0.
  - `load_len`=0 → no effect.
  - `run_start` → RESET_CPU.
  - Both asserted together → `load_start` wins.
  - Start pulses are ignored in LOAD, RESET_CPU and RUN.
- LOAD:
  - `host_ready`=1 while remaining>0.
  - Each beat with `host_valid&&host_ready` decrements remaining and registers one memory write (see Timing); the address then increments.
  - The last accepted beat → RESET_CPU.
- RESET_CPU: `pc_reset`=1 and `cpu_en`=0 for exactly RST_CYC cycles, then → RUN. `cycle_count` is cleared on entry.
- RUN:
  - `pc_reset`=0 and `cpu_en`=1.
  - `cycle_count` increments each cycle and saturates at all-ones.
  - `cpu_halt`=1 → DONE.
  - Else if `wdog_limit`≠0 and `cycle_count`+1 == `wdog_limit` → TIMEOUT.
  - If both occur in the same cycle, halt wins.
- DONE: `done`=1. TIMEOUT: `timeout`=1. In both, `cpu_en`=0 and `pc_reset`=0, so CPU state stays inspectable; `cycle_count` is held.
- `pc_reset`=1 in IDLE, LOAD and RESET_CPU.
- `abort`: → IDLE at the next edge from any state and clears `done`/`timeout`. A write already registered still completes. `abort` has priority over all other events.
- `done`/`timeout` clear on leaving DONE/TIMEOUT.

## Timing
- Write path:
  - Beat accepted at edge N.
  - `load_instruction`=1, `instruction_in`=word and `load_addr`=addr are registered outputs during cycle N..N+1.
  - The memory captures the word at edge N+1.
- One beat per cycle is sustained, with no bubbles.
- `host_ready` drops in the cycle after the last beat is accepted.
- State transitions take effect one edge after the causing input is sampled.
- All outputs are registered except `host_ready`, which is decoded from state and count.
- Asynchronous reset mid-LOAD or mid-RUN: all outputs return to reset values immediately. Partial loads are not resumed.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - State enum and its 3-bit encodings.
  - `WORD_W`=16.
  - Default `RST_CYC`.
- Sub-module `cpu_cycle_counter`: saturating CNT_W counter with clear/enable and the watchdog compare output.
- FSM and load datapath live in `cpu_boot_ctrl`.

## Test plan
- Load `load_len`=3 with words 0x1234, 0x5678, 0x9ABC, `host_valid` held high → writes at addresses 0,1,2 on three consecutive cycles. `host_ready` falls after the third beat. RESET_CPU then lasts 2 cycles with `pc_reset`=1, then RUN with `cpu_en`=1.
- Load with `host_valid` toggling every other cycle → writes occur only on accepted beats and addresses stay contiguous.
- RUN, `cpu_halt` asserted in the 10th RUN cycle → DONE, `done`=1, `cpu_en`=0, `cycle_count`=10.
- `wdog_limit`=5, `cpu_halt` never asserted → TIMEOUT after 5 RUN cycles, `timeout`=1, `cycle_count`=5. Halt and limit in the same cycle → DONE.
- `load_len`=0 → stays IDLE. `load_len`=300 with ADDR_W=8 → exactly 256 beats accepted. `load_start` and `run_start` together in IDLE → LOAD. `run_start` from DONE → rerun without reload.
- `reset_n` low mid-LOAD → immediate IDLE, `pc_reset`=1, `load_instruction`=0. `abort` during RUN → IDLE next edge, `cpu_en`=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU boot/run controller: state encodings and widths.
package cpu_ctrl_pkg;

    // Instruction word width of the 16-bit CPU.
    localparam int unsigned WORD_W = 16;

    // Default number of cycles the PC is held in reset before running.
    localparam int unsigned RST_CYC_DEFAULT = 2;

    // FSM state type and its fixed 3-bit encodings (visible on the state port).
    typedef logic [2:0] boot_state_t;

    localparam boot_state_t StIdle     = 3'd0;
    localparam boot_state_t StLoad     = 3'd1;
    localparam boot_state_t StResetCpu = 3'd2;
    localparam boot_state_t StRun      = 3'd3;
    localparam boot_state_t StDone     = 3'd4;
    localparam boot_state_t StTimeout  = 3'd5;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Host-to-controller program word stream (valid/ready handshake).
interface cpu_boot_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [WORD_W-1:0] host_data;
    logic              host_valid;
    logic              host_ready;

    // Host side drives words; controller side accepts them.
    modport master (output host_data, output host_valid, input host_ready);
    modport slave  (input host_data, input host_valid, output host_ready);

endinterface

// File: rtl/cpu_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and watchdog compare.
module cpu_cycle_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wdog_hit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    // Extra bit keeps a saturated count from aliasing onto a small limit.
    assign wdog_hit_o = (limit_i != '0) &&
                        (({1'b0, count_q} + (CNT_W + 1)'(1)) == {1'b0, limit_i});

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Run controller: loads a program into instruction memory, resets the PC, runs the
// CPU and stops it on halt or watchdog expiry.
module cpu_boot_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RST_CYC = RST_CYC_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              run_start,
    input  logic              abort,
    cpu_boot_ctrl_if.slave    host,
    input  logic              cpu_halt,
    input  logic [CNT_W-1:0]  wdog_limit,
    output logic [WORD_W-1:0] instruction_in,
    output logic              load_instruction,
    output logic [ADDR_W-1:0] load_addr,
    output logic              pc_reset,
    output logic              cpu_en,
    output logic [2:0]        state,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned       RcW     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RcW-1:0]    RcLast  = RcW'(RST_CYC - 1);
    localparam logic [ADDR_W:0]   MaxLen  = {1'b1, {ADDR_W{1'b0}}};

    boot_state_t       state_q, state_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RcW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [WORD_W-1:0] instruction_in_q, instruction_in_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic              load_instruction_q, load_instruction_d;
    logic              pc_reset_q, pc_reset_d;
    logic              cpu_en_q, cpu_en_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              host_ready_w;
    logic              accept;
    logic              cnt_clr;
    logic              cnt_en;
    logic              wdog_hit;

    assign host_ready_w    = (state_q == StLoad) && (remaining_q != '0);
    assign host.host_ready = host_ready_w;
    assign accept          = host.host_valid && host_ready_w;

    // FSM next state and load datapath.
    always_comb begin
        state_d            = state_q;
        remaining_d        = remaining_q;
        addr_d             = addr_q;
        rst_cnt_d          = rst_cnt_q;
        instruction_in_d   = instruction_in_q;
        load_addr_d        = load_addr_q;
        load_instruction_d = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone, StTimeout: begin
                    if (load_start && (load_len != '0)) begin
                        state_d     = StLoad;
                        remaining_d = (load_len > MaxLen) ? MaxLen : load_len;
                        addr_d      = '0;
                    end else if (run_start) begin
                        state_d   = StResetCpu;
                        rst_cnt_d = '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        load_instruction_d = 1'b1;
                        instruction_in_d   = host.host_data;
                        load_addr_d        = addr_q;
                        addr_d             = addr_q + ADDR_W'(1);
                        remaining_d        = remaining_q - (ADDR_W + 1)'(1);
                        if (remaining_q == (ADDR_W + 1)'(1)) begin
                            state_d   = StResetCpu;
                            rst_cnt_d = '0;
                        end
                    end
                end
                StResetCpu: begin
                    if (rst_cnt_q == RcLast) begin
                        state_d = StRun;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RcW'(1);
                    end
                end
                StRun: begin
                    if (cpu_halt) begin
                        state_d = StDone;
                    end else if (wdog_hit) begin
                        state_d = StTimeout;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Registered control/status outputs follow the state being entered.
    always_comb begin
        pc_reset_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StResetCpu);
        cpu_en_d   = (state_d == StRun);
        done_d     = (state_d == StDone);
        timeout_d  = (state_d == StTimeout);
        cnt_clr    = (state_d == StResetCpu) && (state_q != StResetCpu);
        cnt_en     = (state_q == StRun);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            remaining_q        <= '0;
            addr_q             <= '0;
            rst_cnt_q          <= '0;
            instruction_in_q   <= '0;
            load_addr_q        <= '0;
            load_instruction_q <= 1'b0;
            pc_reset_q         <= 1'b1;
            cpu_en_q           <= 1'b0;
            done_q             <= 1'b0;
            timeout_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            remaining_q        <= remaining_d;
            addr_q             <= addr_d;
            rst_cnt_q          <= rst_cnt_d;
            instruction_in_q   <= instruction_in_d;
            load_addr_q        <= load_addr_d;
            load_instruction_q <= load_instruction_d;
            pc_reset_q         <= pc_reset_d;
            cpu_en_q           <= cpu_en_d;
            done_q             <= done_d;
            timeout_q          <= timeout_d;
        end
    end

    cpu_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .limit_i    (wdog_limit),
        .count_o    (cycle_count),
        .wdog_hit_o (wdog_hit)
    );

    assign state            = state_q;
    assign instruction_in   = instruction_in_q;
    assign load_instruction = load_instruction_q;
    assign load_addr        = load_addr_q;
    assign pc_reset         = pc_reset_q;
    assign cpu_en           = cpu_en_q;
    assign done             = done_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed self-checking bench for cpu_boot_ctrl.
module tb_cpu_boot_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              reset_n;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              run_start;
    logic              abort;
    logic              cpu_halt;
    logic [CNT_W-1:0]  wdog_limit;
    logic [15:0]       instruction_in;
    logic              load_instruction;
    logic [ADDR_W-1:0] load_addr;
    logic              pc_reset;
    logic              cpu_en;
    logic [2:0]        state;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;

    cpu_boot_ctrl_if bus ();

    cpu_boot_ctrl #(
        .ADDR_W  (ADDR_W),
        .RST_CYC (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_start       (load_start),
        .load_len         (load_len),
        .run_start        (run_start),
        .abort            (abort),
        .host             (bus),
        .cpu_halt         (cpu_halt),
        .wdog_limit       (wdog_limit),
        .instruction_in   (instruction_in),
        .load_instruction (load_instruction),
        .load_addr        (load_addr),
        .pc_reset         (pc_reset),
        .cpu_en           (cpu_en),
        .state            (state),
        .done             (done),
        .timeout          (timeout),
        .cycle_count      (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: captures on the edge after the strobe is registered.
    logic [15:0] mem [0:255];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (load_instruction === 1'b1) begin
            mem[load_addr] <= instruction_in;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int wr_base  = 0;
    int acc      = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        load_start     = 1'b0;
        load_len       = '0;
        run_start      = 1'b0;
        abort          = 1'b0;
        cpu_halt       = 1'b0;
        wdog_limit     = '0;
        bus.host_data  = '0;
        bus.host_valid = 1'b0;

        // Reset values
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc_reset", 32'(pc_reset), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_host_ready", 32'(bus.host_ready), 32'd0);
        check("rst_load_instr", 32'(load_instruction), 32'd0);
        check("rst_done_timeout", 32'({done, timeout}), 32'd0);
        check("rst_addr_data_cnt", 32'({load_addr, instruction_in}) | 32'(cycle_count), 32'd0);
        reset_n = 1'b1;
        step();

        // load_len = 0 has no effect
        load_start = 1'b1;
        load_len   = '0;
        step();
        load_start = 1'b0;
        check("len0_state", 32'(state), 32'd0);
        check("len0_ready", 32'(bus.host_ready), 32'd0);

        // Three-word back-to-back load
        load_start = 1'b1;
        load_len   = 9'd3;
        step();
        load_start = 1'b0;
        check("ld3_state", 32'(state), 32'd1);
        check("ld3_ready", 32'(bus.host_ready), 32'd1);
        wr_base        = wr_cnt;
        bus.host_valid = 1'b1;
        bus.host_data  = 16'h1234;
        step();
        check("ld3_b0_we", 32'(load_instruction), 32'd1);
        check("ld3_b0_addr", 32'(load_addr), 32'd0);
        check("ld3_b0_data", 32'(instruction_in), 32'h1234);
        bus.host_data = 16'h5678;
        step();
        check("ld3_b1_addr", 32'(load_addr), 32'd1);
        check("ld3_b1_data", 32'(instruction_in), 32'h5678);
        check("ld3_b1_we", 32'(load_instruction), 32'd1);
        bus.host_data = 16'h9ABC;
        step();
        check("ld3_b2_addr", 32'(load_addr), 32'd2);
        check("ld3_b2_data", 32'(instruction_in), 32'h9ABC);
        check("ld3_b2_we", 32'(load_instruction), 32'd1);
        check("ld3_ready_drop", 32'(bus.host_ready), 32'd0);
        check("ld3_rst_state", 32'(state), 32'd2);
        check("ld3_rst_pc", 32'(pc_reset), 32'd1);
        bus.host_valid = 1'b0;
        step();
        check("rstc2_state", 32'(state), 32'd2);
        check("rstc2_we", 32'(load_instruction), 32'd0);
        check("rstc2_pc_en", 32'({pc_reset, cpu_en}), 32'b10);
        step();
        check("run1_state", 32'(state), 32'd3);
        check("run1_pc_en", 32'({pc_reset, cpu_en}), 32'b01);
        check("run1_count", 32'(cycle_count), 32'd0);
        check("ld3_mem0", 32'(mem[0]), 32'h1234);
        check("ld3_mem1", 32'(mem[1]), 32'h5678);
        check("ld3_mem2", 32'(mem[2]), 32'h9ABC);
        check("ld3_writes", 32'(wr_cnt - wr_base), 32'd3);

        // Halt in the 10th RUN cycle
        repeat (9) step();
        check("run10_count", 32'(cycle_count), 32'd9);
        check("run10_state", 32'(state), 32'd3);
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        check("halt_state", 32'(state), 32'd4);
        check("halt_done", 32'(done), 32'd1);
        check("halt_pc_en", 32'({pc_reset, cpu_en}), 32'b00);
        check("halt_count", 32'(cycle_count), 32'd10);
        step();
        check("done_hold_count", 32'(cycle_count), 32'd10);

        // Rerun from DONE without reload; watchdog fires after 5 RUN cycles
        wdog_limit = 16'd5;
        run_start  = 1'b1;
        step();
        run_start = 1'b0;
        check("rerun_state", 32'(state), 32'd2);
        check("rerun_done_clr", 32'(done), 32'd0);
        check("rerun_count_clr", 32'(cycle_count), 32'd0);
        step();
        step();
        check("rerun_run", 32'(state), 32'd3);
        repeat (4) step();
        check("wd_pre_state", 32'(state), 32'd3);
        check("wd_pre_count", 32'(cycle_count), 32'd4);
        step();
        check("wd_state", 32'(state), 32'd5);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_count", 32'(cycle_count), 32'd5);
        check("wd_pc_en", 32'({pc_reset, cpu_en}), 32'b00);

        // Halt and watchdog in the same cycle: halt wins
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        check("tie_timeout_clr", 32'(timeout), 32'd0);
        step();
        step();
        repeat (4) step();
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        check("tie_state", 32'(state), 32'd4);
        check("tie_flags", 32'({done, timeout}), 32'b10);
        check("tie_count", 32'(cycle_count), 32'd5);

        // Load with host_valid toggling every other cycle
        wdog_limit = '0;
        load_start = 1'b1;
        load_len   = 9'd4;
        step();
        load_start = 1'b0;
        check("tog_state", 32'(state), 32'd1);
        wr_base = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.host_valid = (i % 2 == 0);
            bus.host_data  = (i % 2 == 0) ? (16'hA000 + 16'(i / 2)) : 16'hDEAD;
            step();
        end
        bus.host_valid = 1'b0;
        check("tog_rst_state", 32'(state), 32'd2);
        step();
        check("tog_run_state", 32'(state), 32'd3);
        check("tog_writes", 32'(wr_cnt - wr_base), 32'd4);
        check("tog_mem0", 32'(mem[0]), 32'hA000);
        check("tog_mem1", 32'(mem[1]), 32'hA001);
        check("tog_mem2", 32'(mem[2]), 32'hA002);
        check("tog_mem3", 32'(mem[3]), 32'hA003);

        // Abort during RUN
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_pc_en", 32'({pc_reset, cpu_en}), 32'b10);

        // load_start and run_start together with load_len=300: LOAD, capped at 256
        load_start = 1'b1;
        run_start  = 1'b1;
        load_len   = 9'd300;
        step();
        load_start = 1'b0;
        run_start  = 1'b0;
        check("both_state", 32'(state), 32'd1);
        wr_base        = wr_cnt;
        acc            = 0;
        bus.host_valid = 1'b1;
        for (int i = 0; i < 300 && bus.host_ready; i++) begin
            bus.host_data = 16'(acc);
            acc++;
            step();
        end
        bus.host_valid = 1'b0;
        check("cap_beats", 32'(acc), 32'd256);
        check("cap_state", 32'(state), 32'd2);
        step();
        check("cap_writes", 32'(wr_cnt - wr_base), 32'd256);
        check("cap_mem0", 32'(mem[0]), 32'h0000);
        check("cap_mem255", 32'(mem[255]), 32'h00FF);

        // Asynchronous reset mid-LOAD
        abort = 1'b1;
        step();
        abort = 1'b0;
        load_start = 1'b1;
        load_len   = 9'd5;
        step();
        load_start     = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_data  = 16'h1111;
        step();
        bus.host_data = 16'h2222;
        step();
        check("mid_we", 32'(load_instruction), 32'd1);
        check("mid_addr", 32'(load_addr), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_pc_reset", 32'(pc_reset), 32'd1);
        check("arst_we", 32'(load_instruction), 32'd0);
        check("arst_addr_data", 32'({load_addr, instruction_in}), 32'd0);
        check("arst_ready", 32'(bus.host_ready), 32'd0);
        bus.host_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        check("arst_no_resume", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
